struct_packet_summer: RTL and testbench
=======================================

STRUCT_PACKET_SUMMER -- requirements
Module: struct_packet_summer

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, result-queue depth; SHALL be a power of two, 2..16.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port: struct_input  input  some_structs::struct2_t  upstream beat; .valid qualifies; .a_substruct.a_flag=1 marks last beat of packet; .a_substruct.a_vector is payload. No backpressure upstream.
REQ-005 Port: struct_output  output  some_structs::struct2_t  packet result; .valid = result available; .a_vector = packet sum; .a_flag = carry seen.
REQ-006 Port: out_ready  input  1  downstream accepts struct_output when struct_output.valid && out_ready (pop).
REQ-007 Port: fifo_level  output  $clog2(FIFO_DEPTH)+1  number of queued results.
REQ-008 Port: drop_pulse  output  1  one-cycle pulse when a completed result is discarded.
REQ-009 Port: drop_count  output  8  saturating count of discarded results.

Function
REQ-010 FSM states: IDLE (no packet open), ACCUM (packet open, partial sum held).
REQ-011 IDLE, beat with a_flag=0 -> ACCUM; sum<=a_vector; carry<=0.
REQ-012 IDLE, beat with a_flag=1 -> single-beat packet; result {sum=a_vector, carry=0} completes this cycle; stay IDLE.
REQ-013 ACCUM, beat with a_flag=0 -> sum<=sum+a_vector mod 2^32; carry<=carry | carry-out of bit 31; stay ACCUM.
REQ-014 ACCUM, beat with a_flag=1 -> result {sum+a_vector mod 2^32, carry | carry-out} completes; -> IDLE.
REQ-015 Cycles with struct_input.valid=0 SHALL leave FSM, sum and carry unchanged; a_substruct ignored.
REQ-016 Completed result SHALL be pushed into FIFO at the same clock edge that samples the last beat; struct_output.valid SHALL be 1 in the cycle immediately after that edge if FIFO was empty (latency 1 cycle).
REQ-017 struct_output SHALL present FIFO head when fifo_level>0, and all-zero (valid=0, a_flag=0, a_vector=0) when empty.
REQ-018 Pop SHALL remove head; struct_output SHALL hold stable while valid=1 and out_ready=0.
REQ-019 Results SHALL leave in completion order; no reordering, no duplication.
REQ-020 Push when fifo_level<FIFO_DEPTH SHALL succeed; push when full with simultaneous pop SHALL succeed (level unchanged).
REQ-021 Push when full without pop SHALL discard the new result, pulse drop_pulse for exactly that cycle (registered, asserted cycle after edge), increment drop_count; drop_count SHALL saturate at 255.
REQ-022 Simultaneous push and pop when empty is impossible (pop needs valid); pop-only decrements level; push-only increments.
REQ-023 A dropped result SHALL NOT affect FSM; next beat starts a new packet normally.
REQ-024 fifo_level SHALL equal pushes minus pops since reset, never exceeding FIFO_DEPTH.

Reset
REQ-025 While rst=1: FSM->IDLE, sum=0, carry=0, FIFO empty, fifo_level=0, struct_output all-zero, drop_pulse=0, drop_count=0.
REQ-026 Reset mid-packet SHALL discard the partial sum; beats sampled while rst=1 SHALL be ignored.
REQ-027 First beat sampled in the cycle after rst deasserts SHALL be processed normally.

Verification
REQ-028 Three beats 0x10, 0x20, 0x30(last), out_ready=1 -> one result a_vector=0x60, a_flag=0, valid one cycle after last beat, held for one cycle.
REQ-029 Beats 0xFFFF_FFFF, 0x2(last) -> a_vector=0x0000_0001, a_flag=1.
REQ-030 FIFO_DEPTH=4, out_ready=0, five single-beat packets 1..5 -> fifo_level=4, drop_pulse once, drop_count=1; then out_ready=1 -> outputs 1,2,3,4 in order.
REQ-031 Full FIFO, out_ready=1, new packet completes same cycle as pop -> no drop, fifo_level stays 4.
REQ-032 Beats 0x5, 0x7 (no last), rst for one cycle, then 0x9(last) -> single result a_vector=0x9, fifo_level=1.
REQ-033 260 drops with out_ready=0 -> drop_count=255, no wrap.

Source files
------------

// File: rtl/struct_packet_summer.sv
// Packet summer: accumulates 32-bit beats per packet and queues {sum, carry} results.
// Latency: a result is visible on struct_output the cycle after its last beat is sampled.
// Backpressure: none upstream; results wait in the FIFO, and a result completing while it is full with no pop is dropped and counted.

package some_structs;
  typedef struct packed {
    logic        a_flag;
    logic [31:0] a_vector;
  } struct1_t;

  typedef struct packed {
    logic     valid;
    struct1_t a_substruct;
  } struct2_t;
endpackage

// Generic synchronous FIFO; push into a full FIFO is accepted only alongside a pop.
// Latency: a pushed word reaches head_dat the cycle after the push if the FIFO was empty.
// Backpressure: a push into a full FIFO without a pop is ignored; the caller owns the drop policy.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_vld,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop_vld,
  output logic [W-1:0]               head_dat,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign do_pop   = pop_vld && !empty;
  assign do_push  = push_vld && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end
endmodule

// Sums packet beats and hands {sum, carry} results to downstream through a small queue.
// Latency: 1 cycle from the last beat to a valid result when the queue is empty.
// Backpressure: out_ready pops the head; a result completing into a full queue without a pop is dropped.
module struct_packet_summer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  some_structs::struct2_t          struct_input,
  output some_structs::struct2_t          struct_output,
  input  logic                            out_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            drop_pulse,
  output logic [7:0]                      drop_count
);
  typedef enum logic {IDLE, ACCUM} state_t;

  state_t      state;
  logic [31:0] sum;
  logic        carry;

  logic        beat_vld;
  logic        beat_last;
  logic [31:0] beat_dat;
  logic [32:0] add_full;
  logic        res_vld;
  some_structs::struct1_t res_dat;
  some_structs::struct1_t head_dat;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop_vld;
  logic        drop;

  assign beat_vld  = struct_input.valid;
  assign beat_last = struct_input.a_substruct.a_flag;
  assign beat_dat  = struct_input.a_substruct.a_vector;

  // An idle FSM starts a fresh packet, so the stale sum and carry are ignored there.
  assign add_full = (state == ACCUM) ? ({1'b0, sum} + {1'b0, beat_dat}) : {1'b0, beat_dat};
  assign res_dat.a_vector = add_full[31:0];
  assign res_dat.a_flag   = (state == ACCUM) && (carry || add_full[32]);
  assign res_vld          = beat_vld && beat_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sum   <= '0;
      carry <= 1'b0;
    end else if (beat_vld) begin
      if (beat_last) begin
        state <= IDLE;
      end else begin
        state <= ACCUM;
        sum   <= res_dat.a_vector;
        carry <= res_dat.a_flag;
      end
    end
  end

  assign pop_vld = !fifo_empty && out_ready;
  assign drop    = res_vld && fifo_full && !pop_vld;

  sync_fifo #(
    .W     ($bits(some_structs::struct1_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (res_vld),
    .push_dat (res_dat),
    .pop_vld  (pop_vld),
    .head_dat (head_dat),
    .level    (fifo_level),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    struct_output = '0;
    if (!fifo_empty) begin
      struct_output.valid       = 1'b1;
      struct_output.a_substruct = head_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_pulse <= 1'b0;
      drop_count <= '0;
    end else begin
      drop_pulse <= drop;
      if (drop && (drop_count != 8'hFF)) drop_count <= drop_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_struct_packet_summer.sv
// Bench for struct_packet_summer: directed scenarios plus random traffic against a packet-level model.
module tb_struct_packet_summer;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  some_structs::struct2_t struct_input = '0;
  some_structs::struct2_t struct_output;
  logic out_ready = 1'b0;
  logic [$clog2(DEPTH):0] fifo_level;
  logic drop_pulse;
  logic [7:0] drop_count;

  int total = 0;
  int bad = 0;

  // Model: whole-packet arithmetic on 64-bit totals; carry is "total reached 2^32".
  bit              m_open = 1'b0;
  longint unsigned m_total = 0;
  logic [32:0]     m_q[$];
  int              m_cnt = 0;
  bit              m_pulse = 1'b0;

  struct_packet_summer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .struct_input  (struct_input),
    .struct_output (struct_output),
    .out_ready     (out_ready),
    .fifo_level    (fifo_level),
    .drop_pulse    (drop_pulse),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  task automatic step(input bit vld, input bit last, input logic [31:0] vec,
                      input bit rdy, input bit r);
    bit pop;
    longint unsigned t;
    logic [32:0] res;
    struct_input.valid = vld;
    struct_input.a_substruct.a_flag = last;
    struct_input.a_substruct.a_vector = vec;
    out_ready = rdy;
    rst = r;
    @(posedge clk);
    #1;
    if (r) begin
      m_open = 0; m_total = 0; m_q.delete(); m_cnt = 0; m_pulse = 0;
    end else begin
      pop = (m_q.size() > 0) && rdy;
      t = m_open ? m_total + longint'(vec) : longint'(vec);
      res = {((t >> 32) != 0), t[31:0]};
      m_pulse = 0;
      if (pop) void'(m_q.pop_front());
      if (vld && !last) begin
        m_open = 1; m_total = t;
      end else if (vld && last) begin
        m_open = 0;
        if (m_q.size() < DEPTH) m_q.push_back(res);
        else begin
          m_pulse = 1;
          if (m_cnt < 255) m_cnt++;
        end
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, i[0], $urandom, 1'b1, 1'b1);
      total++;
      if (struct_output !== '0 || fifo_level !== '0) begin
        bad++; $display("FAIL reset_out cyc%0d: out=%h level=%0d required out=0 level=0", i, struct_output, fifo_level);
      end
      total++;
      if (drop_pulse !== 1'b0 || drop_count !== 8'd0) begin
        bad++; $display("FAIL reset_drop cyc%0d: pulse=%b count=%0d required 0/0", i, drop_pulse, drop_count);
      end
    end
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    total++;
    if (struct_output.valid !== 1'b0) begin
      bad++; $display("FAIL reset_ignored_beats: valid=%b required 0", struct_output.valid);
    end
  endtask

  task automatic test_three_beats();
    step(1'b1, 1'b0, 32'h10, 1'b1, 1'b0);
    step(1'b1, 1'b0, 32'h20, 1'b1, 1'b0);
    total++;
    if (struct_output.valid !== 1'b0) begin
      bad++; $display("FAIL three_early_valid: valid=%b required 0", struct_output.valid);
    end
    step(1'b1, 1'b1, 32'h30, 1'b1, 1'b0);
    total++;
    if (struct_output !== {1'b1, 1'b0, 32'h60}) begin
      bad++; $display("FAIL three_sum: out=%h required %h", struct_output, {1'b1, 1'b0, 32'h60});
    end
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    total++;
    if (struct_output.valid !== 1'b0 || fifo_level !== '0) begin
      bad++; $display("FAIL three_popped: valid=%b level=%0d required 0/0", struct_output.valid, fifo_level);
    end
  endtask

  task automatic test_carry();
    step(1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h2, 1'b0, 1'b0);
    total++;
    if (struct_output !== {1'b1, 1'b1, 32'h1}) begin
      bad++; $display("FAIL carry_sum: out=%h required %h", struct_output, {1'b1, 1'b1, 32'h1});
    end
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_overflow();
    int npulse = 0;
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 1'b1, 32'(i), 1'b0, 1'b0);
      if (drop_pulse) npulse++;
      total++;
      if (fifo_level !== ((i > DEPTH) ? DEPTH : i)) begin
        bad++; $display("FAIL ovf_level pkt%0d: level=%0d required %0d", i, fifo_level, (i > DEPTH) ? DEPTH : i);
      end
    end
    total++;
    if (drop_pulse !== 1'b1 || drop_count !== 8'd1) begin
      bad++; $display("FAIL ovf_drop: pulse=%b count=%0d required 1/1", drop_pulse, drop_count);
    end
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    if (drop_pulse) npulse++;
    total++;
    if (npulse != 1 || struct_output !== {1'b1, 1'b0, 32'h1}) begin
      bad++; $display("FAIL ovf_hold: pulses=%0d out=%h required 1 and head 1", npulse, struct_output);
    end
    for (int i = 1; i <= 4; i++) begin
      total++;
      if (struct_output !== {1'b1, 1'b0, 32'(i)}) begin
        bad++; $display("FAIL ovf_order idx%0d: out=%h required value %0d", i, struct_output, i);
      end
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    end
    total++;
    if (fifo_level !== '0 || struct_output !== '0) begin
      bad++; $display("FAIL ovf_drained: level=%0d out=%h required 0/0", fifo_level, struct_output);
    end
  endtask

  task automatic test_full_pop();
    for (int i = 11; i <= 14; i++) step(1'b1, 1'b1, 32'(i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'd15, 1'b1, 1'b0);
    total++;
    if (drop_pulse !== 1'b0 || fifo_level !== 3'(DEPTH) || drop_count !== 8'd1) begin
      bad++; $display("FAIL fullpop: pulse=%b level=%0d count=%0d required 0/%0d/1", drop_pulse, fifo_level, drop_count, DEPTH);
    end
    for (int i = 12; i <= 15; i++) begin
      total++;
      if (struct_output !== {1'b1, 1'b0, 32'(i)}) begin
        bad++; $display("FAIL fullpop_order: out=%h required value %0d", struct_output, i);
      end
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_mid_reset();
    step(1'b1, 1'b0, 32'h5, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h7, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 32'h9, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    total++;
    if (fifo_level !== 3'd1 || struct_output !== {1'b1, 1'b0, 32'h9}) begin
      bad++; $display("FAIL midrst: level=%0d out=%h required 1 and value 9", fifo_level, struct_output);
    end
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_saturate();
    int npulse = 0;
    for (int i = 0; i < DEPTH + 260; i++) begin
      step(1'b1, 1'b1, $urandom, 1'b0, 1'b0);
      if (drop_pulse) npulse++;
    end
    total++;
    if (drop_count !== 8'd255 || npulse != 260) begin
      bad++; $display("FAIL saturate: count=%0d pulses=%0d required 255/260", drop_count, npulse);
    end
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    some_structs::struct2_t exp_out;
    int errs = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] v;
      v = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255))) : $urandom;
      step($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, v,
           $urandom_range(0, 2) == 0, $urandom_range(0, 199) == 0);
      exp_out = '0;
      if (m_q.size() > 0) exp_out = {1'b1, m_q[0]};
      total++;
      if (struct_output !== exp_out) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL rand_out cyc%0d: out=%h required %h", i, struct_output, exp_out);
      end
      total++;
      if (fifo_level !== m_q.size() || drop_pulse !== m_pulse || drop_count !== 8'(m_cnt)) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL rand_state cyc%0d: level=%0d pulse=%b count=%0d required %0d/%b/%0d",
                                i, fifo_level, drop_pulse, drop_count, m_q.size(), m_pulse, m_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_three_beats();
    test_carry();
    test_overflow();
    test_full_pop();
    test_mid_reset();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
